// File: rtl/motor_driver.sv
// Two-wheel motor driver: forward PWM drive plus a fixed brake-then-left-turn sequence.
// Outputs are registered from the next-state decode, so they follow the state with no input path.
module motor_driver #(
   parameter int unsigned PWM_PERIOD   = 16,
   parameter int unsigned DUTY         = 12,
   parameter int unsigned BRAKE_CYCLES = 4,
   parameter int unsigned TURN_CYCLES  = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic front,
   input  logic turn,
   output logic left_fwd,
   output logic left_rev,
   output logic right_fwd,
   output logic right_rev,
   output logic busy,
   output logic step_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      BRAKE = 2'd2,
      TURN  = 2'd3
   } state_t;

   localparam logic [15:0] PERIOD_M1 = 16'(PWM_PERIOD - 1);
   localparam logic [15:0] BRAKE_M1  = 16'(BRAKE_CYCLES - 1);
   localparam logic [15:0] TURN_M1   = 16'(TURN_CYCLES - 1);
   localparam logic [15:0] DUTY_C    = 16'(DUTY);

   state_t      state_r, state_s;
   logic [15:0] dwell_r, dwell_s;
   logic [15:0] pwm_r, pwm_s;
   logic [3:0]  motor_r, motor_s;   // {left_fwd, left_rev, right_fwd, right_rev}
   logic        busy_r, busy_s;
   logic        step_done_r, step_done_s;

   // State, counters and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         dwell_r     <= 16'd0;
         pwm_r       <= 16'd0;
         motor_r     <= 4'b0000;
         busy_r      <= 1'b0;
         step_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         dwell_r     <= dwell_s;
         pwm_r       <= pwm_s;
         motor_r     <= motor_s;
         busy_r      <= busy_s;
         step_done_r <= step_done_s;
      end
   end

   // Next-state and next-counter logic; turn outranks front
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (turn)       state_s = BRAKE;
            else if (front) state_s = FWD;
            else            state_s = IDLE;
         end
         FWD: begin
            if (turn)        state_s = BRAKE;
            else if (!front) state_s = IDLE;
            else             state_s = FWD;
         end
         BRAKE: begin
            if (dwell_r == BRAKE_M1) state_s = TURN;
            else                     state_s = BRAKE;
         end
         TURN: begin
            if (dwell_r == TURN_M1) state_s = IDLE;
            else                    state_s = TURN;
         end
         default: state_s = IDLE;
      endcase

      // Dwell restarts on every entry into BRAKE or TURN
      if (((state_s == BRAKE) || (state_s == TURN)) && (state_s == state_r)) begin
         dwell_s = dwell_r + 16'd1;
      end else begin
         dwell_s = 16'd0;
      end

      if ((state_s == FWD) && (state_r == FWD)) begin
         if (pwm_r == PERIOD_M1) pwm_s = 16'd0;
         else                    pwm_s = pwm_r + 16'd1;
      end else begin
         pwm_s = 16'd0;
      end
   end

   // Output decode from the upcoming state and counters
   always_comb begin
      motor_s = 4'b0000;
      case (state_s)
         FWD: begin
            if (pwm_s < DUTY_C) motor_s = 4'b1010;
            else                motor_s = 4'b0000;
         end
         TURN:    motor_s = 4'b0110;
         default: motor_s = 4'b0000;
      endcase
      busy_s      = (state_s == BRAKE) || (state_s == TURN);
      step_done_s = (state_r == TURN) && (state_s == IDLE);
   end

   assign left_fwd  = motor_r[3];
   assign left_rev  = motor_r[2];
   assign right_fwd = motor_r[1];
   assign right_rev = motor_r[0];
   assign busy      = busy_r;
   assign step_done = step_done_r;

endmodule

// File: doc/motor_driver.md
MOTOR_DRIVER -- requirements
Module: motor_driver

Interface
REQ-001 Parameter PWM_PERIOD, default 16, SHALL set the forward PWM period in clk cycles (legal range 1..65535).
REQ-002 Parameter DUTY, default 12, SHALL set the forward on-cycles per period (legal range 0..PWM_PERIOD).
REQ-003 Parameter BRAKE_CYCLES, default 4, SHALL set the all-off dwell before a turn (legal range 1..65535).
REQ-004 Parameter TURN_CYCLES, default 64, SHALL set the left-turn duration in clk cycles (legal range 1..65535).
REQ-005 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 front  input  1  SHALL be the drive-forward command from the navigation FSM, synchronous to clk.
REQ-008 turn  input  1  SHALL be the turn-left command from the navigation FSM, synchronous to clk.
REQ-009 left_fwd, left_rev  output  1 each  SHALL be the left wheel forward and reverse enables.
REQ-010 right_fwd, right_rev  output  1 each  SHALL be the right wheel forward and reverse enables.
REQ-011 busy  output  1  SHALL indicate that a brake/turn sequence is in progress and commands are ignored.
REQ-012 step_done  output  1  SHALL be a one-cycle pulse marking completion of a turn.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, FWD, BRAKE and TURN.
REQ-014 Inputs SHALL be sampled on each rising clk edge, and the state SHALL update on that same edge.
REQ-015 IDLE: turn=1 -> BRAKE; else front=1 -> FWD; else remain in IDLE.
REQ-016 FWD: turn=1 -> BRAKE; else front=0 -> IDLE; else remain in FWD.
REQ-017 When front=1 and turn=1 together, turn SHALL take priority.
REQ-018 BRAKE SHALL last exactly BRAKE_CYCLES cycles, then go to TURN; inputs are ignored during BRAKE.
REQ-019 TURN SHALL last exactly TURN_CYCLES cycles, then go to IDLE; inputs are ignored during TURN.
REQ-020 A 16-bit dwell counter SHALL clear on entry to BRAKE and to TURN, increment each cycle, and end the state when it equals N-1.
REQ-021 A 16-bit PWM counter SHALL clear on entry to FWD, count 0..PWM_PERIOD-1 and wrap to 0, and hold at 0 outside FWD.
REQ-022 In FWD: left_fwd = right_fwd = (pwm_cnt < DUTY); rev outputs = 0.
  - DUTY=0 gives a constant 0 output.
  - DUTY=PWM_PERIOD gives a constant 1 output.
REQ-023 In TURN: left_rev=1 and right_fwd=1; left_fwd=0 and right_rev=0.
REQ-024 In IDLE and BRAKE all four motor outputs SHALL be 0.
REQ-025 Motor outputs and busy SHALL be decoded only from the registered state and counters (Moore), with no combinational path from front or turn.
REQ-026 busy SHALL be 1 in BRAKE and TURN, and 0 in IDLE and FWD.
REQ-027 step_done SHALL be registered and high for exactly the first IDLE cycle following TURN; it SHALL be 0 otherwise.
REQ-028 A wheel's fwd and rev outputs SHALL never both be 1 in any cycle.

Reset
REQ-029 rst_n=0 SHALL asynchronously force the following, independent of clk:
  - state = IDLE
  - both counters = 0
  - all motor outputs, busy and step_done = 0
REQ-030 Reset asserted mid-BRAKE or mid-TURN SHALL abort the sequence with no step_done pulse.
REQ-031 After rst_n deasserts, the first rising edge SHALL evaluate the IDLE transitions normally.

Verification
REQ-032 Reset check: hold rst_n=0 with front=1 -> all outputs 0; release with front=turn=0 for 10 cycles -> outputs stay 0 and state stays IDLE.
REQ-033 Forward PWM (default parameters): front=1 for 48 cycles -> left_fwd=right_fwd=1 on PWM cycles 0-11 and 0 on cycles 12-15 of each period (3 periods); rev outputs=0 and busy=0 throughout.
REQ-034 Turn from FWD: a single-cycle turn=1 while in FWD produces:
  - 4 cycles with all outputs 0 and busy=1
  - then 64 cycles with left_rev=right_fwd=1 and busy=1
  - then one cycle with step_done=1 and busy=0 in IDLE
REQ-035 Ignore during sequence: toggle front and turn randomly during BRAKE/TURN -> timing is unchanged (4+64 cycles) and exactly one step_done pulse occurs.
REQ-036 Priority: front=turn=1 from IDLE -> enters BRAKE (not FWD); with TURN_CYCLES=1 and BRAKE_CYCLES=1, TURN lasts exactly 1 cycle.
REQ-037 Async abort: assert rst_n=0 between clock edges at TURN cycle 30 -> outputs go to 0 before the next edge, and no step_done pulse follows release.
